adc_scan_avg: RTL

ADC_SCAN_AVG -- requirements
Module: adc_scan_avg

---
 rtl/adc_scan_avg.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/adc_scan_avg.sv
// adc_scan_avg: round-robin LTC2308 channel scanner with power-of-two
// per-channel averaging, stale-ready filtering and conversion timeout.
module adc_scan_avg #(
    parameter int NCH      = 8,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 64,
    parameter bit UNI      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        adc_start,
    output logic [5:0]  adc_conf,
    input  logic [11:0] adc_res,
    input  logic        adc_ready,
    output logic [11:0] sample,
    output logic [2:0]  sample_ch,
    output logic        sample_valid,
    output logic        timeout_err,
    output logic        busy
);
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] NSAMP    = CW'(2 ** AVG_LOG2);
    localparam logic [2:0]    LAST_CH  = 3'(NCH - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, START, WAIT_LOW, WAIT_HIGH, ACC, EMIT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    ch_q, ch_d, ch_nxt;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          st_q, st_d;
    logic          adc_start_q, adc_start_d;
    logic [5:0]    adc_conf_q, adc_conf_d;
    logic [11:0]   sample_q, sample_d;
    logic [2:0]    sample_ch_q, sample_ch_d;
    logic          sample_valid_q, sample_valid_d;
    logic          timeout_err_q, timeout_err_d;
    logic          busy_q, busy_d;

    assign ch_nxt  = (ch_q == LAST_CH) ? 3'd0 : ch_q + 3'd1;
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        tmo_d         = '0;
        st_d          = 1'b0;
        sample_d      = sample_q;
        sample_ch_d   = sample_ch_q;
        timeout_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                st_d = ~st_q;
                if (st_q) state_d = WAIT_LOW;
            end
            WAIT_LOW, WAIT_HIGH: begin
                tmo_d = tmo_q + TW'(1);
                // A capture on the last allowed cycle still counts.
                if (state_q == WAIT_HIGH && adc_ready) begin
                    acc_d   = acc_q + AW'(adc_res);
                    state_d = ACC;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    acc_d         = '0;
                    cnt_d         = '0;
                    ch_d          = ch_nxt;
                    state_d       = en ? START : IDLE;
                end else if (state_q == WAIT_LOW && !adc_ready) begin
                    state_d = WAIT_HIGH;
                end
            end
            ACC: begin
                cnt_d = cnt_inc;
                if (!en) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_inc < NSAMP) begin
                    state_d = START;
                end else begin
                    sample_d    = 12'(acc_q >> AVG_LOG2);
                    sample_ch_d = ch_q;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                acc_d   = '0;
                cnt_d   = '0;
                ch_d    = ch_nxt;
                state_d = en ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
        adc_start_d    = (state_d == START);
        sample_valid_d = (state_d == EMIT);
        busy_d         = (state_d != IDLE);
        adc_conf_d     = {1'b1, ch_d[0], ch_d[2], ch_d[1], UNI, 1'b0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            ch_q           <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            tmo_q          <= '0;
            st_q           <= 1'b0;
            adc_start_q    <= 1'b0;
            adc_conf_q     <= {1'b1, 3'b000, UNI, 1'b0};
            sample_q       <= '0;
            sample_ch_q    <= '0;
            sample_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            st_q           <= st_d;
            adc_start_q    <= adc_start_d;
            adc_conf_q     <= adc_conf_d;
            sample_q       <= sample_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            timeout_err_q  <= timeout_err_d;
            busy_q         <= busy_d;
        end
    end

    assign adc_start    = adc_start_q;
    assign adc_conf     = adc_conf_q;
    assign sample       = sample_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = sample_valid_q;
    assign timeout_err  = timeout_err_q;
    assign busy         = busy_q;
endmodule
